// File: rtl/ifetch_mem_ctrl.sv
// Miss-side instruction fetch: four byte reads from the RAM port, assembled little-endian.
// Define IFETCH_PREFETCH_EN to add a one-entry next-word prefetch buffer (PREF state).
module ifetch_mem_ctrl #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_flush,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        fetch_busy,
  output logic [31:0] mem_a,
  output logic        mem_req,
  output logic        mem_wr,
  input  logic [7:0]  mem_din
);
  // Byte i is issued at cnt=i and lands RAM_LAT cycles later, so the last capture is at 3+RAM_LAT.
  localparam logic [2:0] CNT_LAST = 3'(3 + RAM_LAT);

`ifdef IFETCH_PREFETCH_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_PREF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_eff;
  logic [31:0] addr_q, addr_d, word_q, word_d, inst_q, inst_d, req_addr;
  logic        paused_q, in_engine, last_step, start;
`ifdef IFETCH_PREFETCH_EN
  logic        buf_vld_q, buf_vld_d, addr_hit;
  assign addr_hit  = (req_addr == addr_q);
  assign in_engine = (state_q == S_FETCH) || (state_q == S_PREF);
`else
  assign in_engine = (state_q == S_FETCH);
`endif

  assign req_addr  = fetch_addr & 32'hFFFF_FFFC;
  // RAM data seen across a pause is untrusted, so the first ready cycle re-issues byte 0.
  assign cnt_eff   = (paused_q && rdy_in) ? 3'd0 : cnt_q;
  assign last_step = (cnt_eff == CNT_LAST);

  assign mem_req     = in_engine && (cnt_eff < 3'd4);
  assign mem_a       = mem_req ? addr_q + {30'd0, cnt_eff[1:0]} : 32'd0;
  assign mem_wr      = 1'b0;
  assign fetch_busy  = (state_q == S_FETCH) || (state_q == S_DONE);
  assign fetch_valid = (state_q == S_DONE) && rdy_in && !fetch_flush;
  assign fetch_inst  = fetch_valid ? word_q : inst_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    inst_d  = inst_q;
    start   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    buf_vld_d = buf_vld_q;
`endif
    if (rdy_in) begin
      if (in_engine) begin
        case (cnt_eff)
          3'd1:    word_d[7:0]   = mem_din;
          3'd2:    word_d[15:8]  = mem_din;
          3'd3:    word_d[23:16] = mem_din;
          3'd4:    word_d[31:24] = mem_din;
          default: ;
        endcase
        cnt_d = last_step ? 3'd0 : cnt_eff + 3'd1;
      end
      case (state_q)
        S_IDLE: begin
          start = fetch_req;
`ifdef IFETCH_PREFETCH_EN
          if (fetch_req && buf_vld_q && addr_hit) begin
            start   = 1'b0;
            state_d = S_DONE;
          end
`endif
        end
        S_FETCH: if (last_step) state_d = S_DONE;
        S_DONE: begin
          inst_d = word_q;
`ifdef IFETCH_PREFETCH_EN
          state_d   = S_PREF;
          addr_d    = addr_q + 32'd4;
          cnt_d     = 3'd0;
          buf_vld_d = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end
`ifdef IFETCH_PREFETCH_EN
        // A request for the word being prefetched turns the prefetch into the demand fetch.
        S_PREF: begin
          if (fetch_req && !addr_hit) start = 1'b1;
          else if (fetch_req)         state_d = last_step ? S_DONE : S_FETCH;
          else if (last_step) begin
            state_d   = S_IDLE;
            buf_vld_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
      if (fetch_flush) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        inst_d  = inst_q;
        start   = fetch_req;
      end
      if (start) begin
        state_d = S_FETCH;
        cnt_d   = 3'd0;
        addr_d  = req_addr;
      end
`ifdef IFETCH_PREFETCH_EN
      if (start || fetch_flush) buf_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= 32'd0;
      word_q   <= 32'd0;
      inst_q   <= 32'd0;
      paused_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      buf_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      inst_q  <= inst_d;
      if (!rdy_in) begin
        if (in_engine) paused_q <= 1'b1;
      end else begin
        paused_q <= 1'b0;
      end
`ifdef IFETCH_PREFETCH_EN
      buf_vld_q <= buf_vld_d;
`endif
    end
  end
endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Bench for ifetch_mem_ctrl: behavioural byte-RAM, per-cycle model compare, directed latency cases.
module tb_ifetch_mem_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_req, fetch_flush;
  logic [31:0] fetch_addr;
  logic        fetch_valid, fetch_busy, mem_req, mem_wr;
  logic [31:0] fetch_inst, mem_a;
  logic [7:0]  mem_din = 8'h00;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  ifetch_mem_ctrl #(.RAM_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_busy(fetch_busy),
    .mem_a(mem_a), .mem_req(mem_req), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  function automatic logic [7:0] rb(input logic [31:0] a);
    case (a)
      32'h1000: rb = 8'h13;
      32'h1001: rb = 8'h05;
      32'h1002: rb = 8'hA0;
      32'h1003: rb = 8'h00;
      default:  rb = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {rb(a + 3), rb(a + 2), rb(a + 1), rb(a)};
  endfunction

  // One-cycle RAM; data returned across a pause cycle is garbage.
  always @(posedge clk_in) mem_din <= rdy_in ? rb(mem_a) : 8'($urandom);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: age = cycles since a fetch was accepted (-1 idle); 0..3 issue bytes, 5 delivers.
  int          m_age = -1;
  logic        m_restart = 1'b0;
  logic [31:0] m_A = 32'd0, m_inst = 32'd0;

  function automatic int eff_age();
    return (m_restart && rdy_in) ? 0 : m_age;
  endfunction

  always @(posedge clk_in or negedge rst_in) begin : model
    int e;
    if (!rst_in) begin
      m_age = -1; m_restart = 1'b0; m_A = 32'd0; m_inst = 32'd0;
    end else if (!rdy_in) begin
      if (m_age >= 0 && m_age <= 4) m_restart = 1'b1;
    end else begin
      e = eff_age();
      m_restart = 1'b0;
      if (fetch_flush) begin
        m_age = fetch_req ? 0 : -1;
        if (fetch_req) m_A = {fetch_addr[31:2], 2'b00};
      end else if (e < 0) begin
        if (fetch_req) begin m_age = 0; m_A = {fetch_addr[31:2], 2'b00}; end
      end else if (e < 5) begin
        m_age = e + 1;
      end else begin
        m_inst = word_at(m_A);
        m_age  = -1;
      end
    end
  end

  always @(negedge clk_in) begin : compare
    int e;
    logic ev, er;
    if (!rst_in) begin
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_inst", fetch_inst, 32'd0);
      chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    end else begin
      chk("mem_wr", {31'd0, mem_wr}, 32'd0);
`ifndef IFETCH_PREFETCH_EN
      e  = eff_age();
      ev = (e == 5) && rdy_in && !fetch_flush;
      er = (e >= 0) && (e <= 3);
      chk("valid", {31'd0, fetch_valid}, {31'd0, ev});
      chk("inst", fetch_inst, ev ? word_at(m_A) : m_inst);
      chk("busy", {31'd0, fetch_busy}, {31'd0, (e >= 0)});
      chk("mem_req", {31'd0, mem_req}, {31'd0, er});
      chk("mem_a", mem_a, er ? m_A + 32'(e) : 32'd0);
`endif
    end
  end

  int          n_valid = 0, last_vcyc = 0;
  logic [31:0] last_vinst = 32'd0, first_ma = 32'd0;
  logic        prev_req = 1'b0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (fetch_valid) begin n_valid++; last_vcyc = cyc; last_vinst = fetch_inst; end
      if (mem_req && !prev_req) first_ma = mem_a;
      prev_req = mem_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int vcyc);
    int n0;
    n0 = n_valid;
    vcyc = -1;
    repeat (budget) begin
      @(negedge clk_in); #1;
      if (n_valid != n0) begin vcyc = last_vcyc; break; end
    end
    if (vcyc < 0) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got none want fetch_valid within %0d cycles", budget);
    end
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    int e0, v, v1, nb;
    rst_in = 1'b0; rdy_in = 1'b1; fetch_req = 1'b0; fetch_flush = 1'b0; fetch_addr = 32'd0;
    tick(3);
    rst_in = 1'b1;
    tick(2);

    // Plain miss
    fetch_req = 1'b1; fetch_addr = 32'h1000; e0 = cyc + 1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("t1_latency", 32'(v - e0), 32'd5);
    chk("t1_inst", last_vinst, 32'h00A00513);
    chk("t1_first_mem_a", first_ma, 32'h1000);
    tick(3);
    chk("t1_inst_hold", fetch_inst, 32'h00A00513);

    // Low address bits ignored
    fetch_req = 1'b1; fetch_addr = 32'h1002; e0 = cyc + 1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("t2_first_mem_a", first_ma, 32'h1000);
    chk("t2_inst", last_vinst, 32'h00A00513);
    chk("t2_latency", 32'(v - e0), 32'd5);
    tick(2);

    // Flush mid-fetch with a simultaneous new request
    nb = n_valid;
    fetch_req = 1'b1; fetch_addr = 32'h2000;
    tick(3);
    fetch_flush = 1'b1; fetch_addr = 32'h3000;
    tick(); fetch_flush = 1'b0; e0 = cyc;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("t3_latency", 32'(v - e0), 32'd5);
    chk("t3_inst", last_vinst, 32'h69686B6A);
    chk("t3_one_valid", 32'(n_valid - nb), 32'd1);
    tick(2);

    // Pause after two byte addresses, restart from byte 0
    fetch_req = 1'b1; fetch_addr = 32'h1000; e0 = cyc + 1;
    tick(3); rdy_in = 1'b0;
    tick(4); rdy_in = 1'b1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("t4_latency", 32'(v - e0), 32'd11);
    chk("t4_inst", last_vinst, 32'h00A00513);
    tick(2);

    // Asynchronous reset mid-fetch
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    tick(2);
    #2 rst_in = 1'b0;
    #1;
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_mem_a", mem_a, 32'd0);
    chk("t5_busy", {31'd0, fetch_busy}, 32'd0);
    chk("t5_inst", fetch_inst, 32'd0);
    fetch_req = 1'b0;
    tick(2); rst_in = 1'b1; nb = n_valid;
    tick(12);
    chk("t5_no_valid", 32'(n_valid - nb), 32'd0);

    // Flush in the delivery cycle suppresses the valid
    nb = n_valid;
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    tick(6);
    fetch_req = 1'b0; fetch_flush = 1'b1;
    tick(); fetch_flush = 1'b0;
    tick(3);
    chk("t6_suppressed", 32'(n_valid - nb), 32'd0);
    chk("t6_inst_hold", fetch_inst, 32'd0);

    // Back-to-back: request presented in the idle cycle right after delivery
    fetch_req = 1'b1; fetch_addr = 32'h1000;
    wait_valid(20, v1);
    fetch_addr = 32'h3000;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("t7_b2b_latency", 32'(v - (v1 + 2)), 32'd5);
    chk("t7_inst", last_vinst, 32'h69686B6A);
    tick(2);

`ifdef IFETCH_PREFETCH_EN
    fetch_req = 1'b1; fetch_addr = 32'h1000; e0 = cyc + 1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("p_miss_latency", 32'(v - e0), 32'd5);
    tick(6);
    fetch_req = 1'b1; fetch_addr = 32'h1004; e0 = cyc + 1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("p_hit_latency", 32'(v - e0), 32'd0);
    chk("p_hit_inst", last_vinst, 32'h4D4C4F4E);
    fetch_flush = 1'b1;
    tick(); fetch_flush = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h1008; e0 = cyc + 1;
    wait_valid(20, v); fetch_req = 1'b0;
    chk("p_flushed_latency", 32'(v - e0), 32'd5);
    tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
